traffic_light_ctrl: RTL and testbench

Parametrised two-road intersection controller. Main road (NS) and side road (EW) each have red/yellow/green lamps. Phase durations are set by parameters and counted in ticks of an external time-base strobe. The controller adds side-road demand sensing, an all-red clearance interval and a flashing-yellow maintenance mode. It sits beside the existing single-lamp sequencer and drives the lamp-driver block.

---
 rtl/traffic_light_ctrl_if.sv | 40 ++++
 rtl/traffic_light_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the intersection controller, its time-base strobe and the lamp driver.
// With PED_WALK_EN defined it also carries the pedestrian request and the walk lamp.
interface traffic_light_ctrl_if;
    logic       tick_i;
    logic       ew_req_i;
    logic       flash_mode_i;
    logic       ns_red_o;
    logic       ns_yellow_o;
    logic       ns_green_o;
    logic       ew_red_o;
    logic       ew_yellow_o;
    logic       ew_green_o;
    logic [2:0] state_o;
`ifdef PED_WALK_EN
    logic       ped_req_i;
    logic       walk_o;
`endif

    modport master (
        output tick_i, ew_req_i, flash_mode_i,
`ifdef PED_WALK_EN
        output ped_req_i,
        input  walk_o,
`endif
        input  ns_red_o, ns_yellow_o, ns_green_o,
        input  ew_red_o, ew_yellow_o, ew_green_o,
        input  state_o
    );

    modport slave (
        input  tick_i, ew_req_i, flash_mode_i,
`ifdef PED_WALK_EN
        input  ped_req_i,
        output walk_o,
`endif
        output ns_red_o, ns_yellow_o, ns_green_o,
        output ew_red_o, ew_yellow_o, ew_green_o,
        output state_o
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller: demand-driven side road, all-red clearance, flashing-yellow mode.
// Optional pedestrian walk phase enabled by defining PED_WALK_EN.
//
//   state | meaning
//   NSG   | main road green, waits for side-road demand after its minimum
//   NSY   | main road yellow
//   AR1   | all-red clearance before side-road green
//   EWG   | side road green, fixed duration
//   EWY   | side road yellow
//   AR2   | all-red clearance before main-road green (reset state)
//   FLASH | maintenance: both yellows blink on each tick
//   WALK  | pedestrian walk, all vehicle lamps red (PED_WALK_EN only)
module traffic_light_ctrl #(
    parameter int CNT_W        = 8,
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 2,
    parameter int WALK_TICKS   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    traffic_light_ctrl_if.slave  bus
);

    localparam longint MAX_DUR = (64'd1 << CNT_W) - 64'd1;

    if (GREEN_TICKS < 1 || GREEN_TICKS > MAX_DUR) begin : g_bad_green
        $error("traffic_light_ctrl: GREEN_TICKS out of range");
    end
    if (YELLOW_TICKS < 1 || YELLOW_TICKS > MAX_DUR) begin : g_bad_yellow
        $error("traffic_light_ctrl: YELLOW_TICKS out of range");
    end
    if (ALLRED_TICKS < 1 || ALLRED_TICKS > MAX_DUR) begin : g_bad_allred
        $error("traffic_light_ctrl: ALLRED_TICKS out of range");
    end
    if (WALK_TICKS < 1 || WALK_TICKS > MAX_DUR) begin : g_bad_walk
        $error("traffic_light_ctrl: WALK_TICKS out of range");
    end

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TICKS - 1);
`ifdef PED_WALK_EN
    localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_TICKS - 1);
`endif

    typedef enum logic [2:0] {
        S_NSG   = 3'd0,
        S_NSY   = 3'd1,
        S_AR1   = 3'd2,
        S_EWG   = 3'd3,
        S_EWY   = 3'd4,
        S_AR2   = 3'd5,
        S_FLASH = 3'd6
`ifdef PED_WALK_EN
        , S_WALK = 3'd7
`endif
    } state_e;

    // Lamp vector order: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
    localparam logic [5:0] LAMPS_ALLRED = 6'b100_100;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ew_pend_q, ew_pend_d;
    logic             flash_ph_q, flash_ph_d;
    logic [5:0]       lamps_q, lamps_d;
    logic             expire;
`ifdef PED_WALK_EN
    logic             ped_pend_q, ped_pend_d;
    logic             walk_ret_q, walk_ret_d;
    logic             walk_q, walk_d;
`endif

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        ew_pend_d  = ew_pend_q | bus.ew_req_i;
        flash_ph_d = 1'b0;
        expire     = bus.tick_i && (timer_q == '0);
`ifdef PED_WALK_EN
        ped_pend_d = ped_pend_q | bus.ped_req_i;
        walk_ret_d = walk_ret_q;
`endif

        if (bus.flash_mode_i) begin
            state_d    = S_FLASH;
            flash_ph_d = (state_q == S_FLASH) ? (flash_ph_q ^ bus.tick_i) : 1'b1;
        end else if (state_q == S_FLASH) begin
            state_d = S_AR2;
            timer_d = ALLRED_LD;
        end else begin
            if (bus.tick_i && (timer_q != '0)) begin
                timer_d = timer_q - CNT_W'(1);
            end
            // NSG with no demand falls through with the timer parked at zero
            case (state_q)
                S_NSG: if (expire && ew_pend_q) begin
                    state_d = S_NSY;
                    timer_d = YELLOW_LD;
                end
                S_NSY: if (expire) begin
                    state_d = S_AR1;
                    timer_d = ALLRED_LD;
                end
                S_AR1: if (expire) begin
`ifdef PED_WALK_EN
                    if (ped_pend_q) begin
                        state_d    = S_WALK;
                        timer_d    = WALK_LD;
                        walk_ret_d = 1'b1;
                    end else begin
                        state_d = S_EWG;
                        timer_d = GREEN_LD;
                    end
`else
                    state_d = S_EWG;
                    timer_d = GREEN_LD;
`endif
                end
                S_EWG: if (expire) begin
                    state_d = S_EWY;
                    timer_d = YELLOW_LD;
                end
                S_EWY: if (expire) begin
                    state_d = S_AR2;
                    timer_d = ALLRED_LD;
                end
                S_AR2: if (expire) begin
`ifdef PED_WALK_EN
                    if (ped_pend_q) begin
                        state_d    = S_WALK;
                        timer_d    = WALK_LD;
                        walk_ret_d = 1'b0;
                    end else begin
                        state_d = S_NSG;
                        timer_d = GREEN_LD;
                    end
`else
                    state_d = S_NSG;
                    timer_d = GREEN_LD;
`endif
                end
`ifdef PED_WALK_EN
                S_WALK: if (expire) begin
                    state_d = walk_ret_q ? S_EWG : S_NSG;
                    timer_d = GREEN_LD;
                end
`endif
                default: begin
                    state_d = S_AR2;
                    timer_d = ALLRED_LD;
                end
            endcase
        end

        if ((state_d == S_EWG) && (state_q != S_EWG)) begin
            ew_pend_d = 1'b0;
        end
`ifdef PED_WALK_EN
        if ((state_d == S_WALK) && (state_q != S_WALK)) begin
            ped_pend_d = 1'b0;
        end
        walk_d = (state_d == S_WALK);
`endif

        // Lamps are decoded from the next state so they register in step with state_q
        lamps_d = LAMPS_ALLRED;
        case (state_d)
            S_NSG:   lamps_d = 6'b001_100;
            S_NSY:   lamps_d = 6'b010_100;
            S_EWG:   lamps_d = 6'b100_001;
            S_EWY:   lamps_d = 6'b100_010;
            S_FLASH: lamps_d = {1'b0, flash_ph_d, 1'b0, 1'b0, flash_ph_d, 1'b0};
            default: lamps_d = LAMPS_ALLRED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_AR2;
            timer_q    <= ALLRED_LD;
            ew_pend_q  <= 1'b0;
            flash_ph_q <= 1'b0;
            lamps_q    <= LAMPS_ALLRED;
`ifdef PED_WALK_EN
            ped_pend_q <= 1'b0;
            walk_ret_q <= 1'b0;
            walk_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ew_pend_q  <= ew_pend_d;
            flash_ph_q <= flash_ph_d;
            lamps_q    <= lamps_d;
`ifdef PED_WALK_EN
            ped_pend_q <= ped_pend_d;
            walk_ret_q <= walk_ret_d;
            walk_q     <= walk_d;
`endif
        end
    end

    assign bus.state_o     = state_q;
    assign bus.ns_red_o    = lamps_q[5];
    assign bus.ns_yellow_o = lamps_q[4];
    assign bus.ns_green_o  = lamps_q[3];
    assign bus.ew_red_o    = lamps_q[2];
    assign bus.ew_yellow_o = lamps_q[1];
    assign bus.ew_green_o  = lamps_q[0];
`ifdef PED_WALK_EN
    assign bus.walk_o      = walk_q;
`endif

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with GREEN=4, YELLOW=2, ALLRED=1.
// Inputs driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_traffic_light_ctrl;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   ewg_cnt;
    int   found;

    traffic_light_ctrl_if bus ();

    traffic_light_ctrl #(
        .CNT_W        (8),
        .GREEN_TICKS  (4),
        .YELLOW_TICKS (2),
        .ALLRED_TICKS (1),
        .WALK_TICKS   (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [5:0] lamps;
    assign lamps = {bus.ns_red_o, bus.ns_yellow_o, bus.ns_green_o,
                    bus.ew_red_o, bus.ew_yellow_o, bus.ew_green_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] exp_lamps(input int s);
        case (s)
            0:       return 6'b001100;
            1:       return 6'b010100;
            3:       return 6'b100001;
            4:       return 6'b100010;
            default: return 6'b100100;
        endcase
    endfunction

    // Pulse reset between clock edges; the next rising edge leaves AR2 for NSG.
    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    int exp_seq [20] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 4, 4, 5, 0, 0, 0, 0, 0, 0};

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        ewg_cnt = 0;
        found   = 0;
        bus.tick_i       = 1'b1;
        bus.ew_req_i     = 1'b0;
        bus.flash_mode_i = 1'b0;
        rst_n            = 1'b1;

        // Reset and release
        #1 rst_n = 1'b0;
        #2;
        chk("rst_state", 32'(bus.state_o), 5);
        chk("rst_lamps", 32'(lamps), 32'(6'b100100));
        @(negedge clk);
        chk("rst_hold_state", 32'(bus.state_o), 5);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_state", 32'(bus.state_o), 0);
        chk("rel_ns_green", 32'(bus.ns_green_o), 1);

        // No demand: NSG holds
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_state", 32'(bus.state_o), 0);
            chk("idle_lamps", 32'(lamps), 32'(6'b001100));
        end

        // One full cycle from a 1-cycle request in the first NSG cycle
        pulse_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("cycle_state", 32'(bus.state_o), 32'(exp_seq[i]));
            chk("cycle_lamps", 32'(lamps), 32'(exp_lamps(exp_seq[i])));
            if (bus.ew_green_o) ewg_cnt++;
            if (i == 0) bus.ew_req_i = 1'b1;
            if (i == 1) bus.ew_req_i = 1'b0;
        end
        chk("ewg_cycles", 32'(ewg_cnt), 4);

        // Tick stalled in NSY
        bus.ew_req_i = 1'b1;
        @(negedge clk);
        chk("req_latch_state", 32'(bus.state_o), 0);
        bus.ew_req_i = 1'b0;
        @(negedge clk);
        chk("nsy_entry", 32'(bus.state_o), 1);
        bus.tick_i = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("nsy_stall", 32'(bus.state_o), 1);
        end
        bus.tick_i = 1'b1;
        @(negedge clk);
        chk("nsy_resume", 32'(bus.state_o), 1);
        @(negedge clk);
        chk("ar1_after_nsy", 32'(bus.state_o), 2);
        @(negedge clk);
        chk("ewg_entry", 32'(bus.state_o), 3);
        @(negedge clk);
        chk("ewg_second", 32'(bus.state_o), 3);

        // Flashing mode entered mid-EWG, with a side-road request made while flashing
        bus.flash_mode_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("flash_state", 32'(bus.state_o), 6);
            chk("flash_lamps", 32'(lamps),
                (i % 2 == 0) ? 32'(6'b010010) : 32'(6'b000000));
            bus.ew_req_i = (i == 0);
        end
        bus.flash_mode_i = 1'b0;
        @(negedge clk);
        chk("flash_exit_ar2", 32'(bus.state_o), 5);
        chk("flash_exit_lamps", 32'(lamps), 32'(6'b100100));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_flash_nsg", 32'(bus.state_o), 0);
        end
        @(negedge clk);
        chk("pend_kept_nsy", 32'(bus.state_o), 1);

        // Asynchronous reset in EWY clears the pending request
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (bus.state_o == 3'd4) found = 1;
        end
        chk("ewy_reached", 32'(found), 1);
        bus.ew_req_i = 1'b1;
        @(negedge clk);
        bus.ew_req_i = 1'b0;
        chk("ewy_second", 32'(bus.state_o), 4);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(bus.state_o), 5);
        chk("async_rst_lamps", 32'(lamps), 32'(6'b100100));
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("pend_cleared_nsg", 32'(bus.state_o), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
